mac_seq_ctrl: RTL and testbench



---
 rtl/mac_seq_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_mac_seq_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: computes one unsigned dot product per job on a pipelined
// 8x8->24 MAC.
// - Paired operands are popped from two FWFT FIFOs (A and B) and streamed
//   into the MAC.
// - The MAC pipeline is then flushed with zero products.
// - Cout is captured and presented on a valid/ready result port.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_start, i_len        job request (sampled in IDLE) and pair count
//   o_busy                high in every state except IDLE
//   i_a_empty, i_a_data   A FIFO status / head word
//   o_a_rden              A FIFO pop (combinational on this cycle's empties)
//   i_b_empty, i_b_data   B FIFO status / head word
//   o_b_rden              B FIFO pop (always equal to o_a_rden)
//   o_mac_en, o_mac_clr   MAC enable / clear (never both high)
//   o_mac_a, o_mac_b      MAC operands
//   i_mac_cout            MAC accumulated result
//   o_res_data            dot-product result
//   o_res_valid           result valid
//   i_res_ready           consumer accepts result
module mac_seq_ctrl #(
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned MAC_LAT = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_busy,
  input  logic             i_a_empty,
  input  logic [7:0]       i_a_data,
  output logic             o_a_rden,
  input  logic             i_b_empty,
  input  logic [7:0]       i_b_data,
  output logic             o_b_rden,
  output logic             o_mac_en,
  output logic             o_mac_clr,
  output logic [7:0]       o_mac_a,
  output logic [7:0]       o_mac_b,
  input  logic [23:0]      i_mac_cout,
  output logic [23:0]      o_res_data,
  output logic             o_res_valid,
  input  logic             i_res_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_count;
  logic             r_busy;
  logic             r_mac_en;
  logic             r_mac_clr;
  logic [7:0]       r_mac_a;
  logic [7:0]       r_mac_b;
  logic [23:0]      r_res_data;
  logic             r_res_valid;

  state_t           w_state_nxt;
  logic [LEN_W-1:0] w_len_nxt;
  logic [LEN_W-1:0] w_count_nxt;
  logic             w_mac_en_nxt;
  logic             w_mac_clr_nxt;
  logic [7:0]       w_mac_a_nxt;
  logic [7:0]       w_mac_b_nxt;
  logic [23:0]      w_res_data_nxt;
  logic             w_res_valid_nxt;
  logic             w_fire;

  // A pair is taken only when both heads are present, so the two FIFOs
  // always advance together.
  assign w_fire   = (r_state == S_FEED) && !i_a_empty && !i_b_empty;
  assign o_a_rden = w_fire;
  assign o_b_rden = w_fire;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_count     <= '0;
      r_busy      <= 1'b0;
      r_mac_en    <= 1'b0;
      r_mac_clr   <= 1'b0;
      r_mac_a     <= '0;
      r_mac_b     <= '0;
      r_res_data  <= '0;
      r_res_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_len       <= w_len_nxt;
      r_count     <= w_count_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_mac_en    <= w_mac_en_nxt;
      r_mac_clr   <= w_mac_clr_nxt;
      r_mac_a     <= w_mac_a_nxt;
      r_mac_b     <= w_mac_b_nxt;
      r_res_data  <= w_res_data_nxt;
      r_res_valid <= w_res_valid_nxt;
    end
  end

  // Outputs are registered from next-state values, so each strobe lines up
  // with the state it belongs to (e.g. mac_clr is high for the CLEAR cycle).
  always_comb begin
    w_state_nxt     = r_state;
    w_len_nxt       = r_len;
    w_count_nxt     = r_count;
    w_mac_en_nxt    = 1'b0;
    w_mac_clr_nxt   = 1'b0;
    w_mac_a_nxt     = r_mac_a;
    w_mac_b_nxt     = r_mac_b;
    w_res_data_nxt  = r_res_data;
    w_res_valid_nxt = r_res_valid;

    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_len_nxt     = i_len;
          w_count_nxt   = '0;
          w_mac_clr_nxt = 1'b1;
          w_state_nxt   = S_CLEAR;
        end
      end

      S_CLEAR: begin
        w_count_nxt = '0;
        w_state_nxt = (r_len != '0) ? S_FEED : S_DRAIN;
      end

      S_FEED: begin
        if (w_fire) begin
          w_mac_en_nxt = 1'b1;
          w_mac_a_nxt  = i_a_data;
          w_mac_b_nxt  = i_b_data;
          if (r_count == r_len - LEN_W'(1)) begin
            // count is reused as the drain counter
            w_count_nxt = '0;
            w_state_nxt = S_DRAIN;
          end else begin
            w_count_nxt = r_count + LEN_W'(1);
          end
        end
      end

      S_DRAIN: begin
        if (r_count == LEN_W'(MAC_LAT)) begin
          w_res_data_nxt  = i_mac_cout;
          w_res_valid_nxt = 1'b1;
          w_count_nxt     = '0;
          w_state_nxt     = S_DONE;
        end else begin
          // zero products push the last real pair through without
          // changing the sum
          w_mac_en_nxt = 1'b1;
          w_mac_a_nxt  = '0;
          w_mac_b_nxt  = '0;
          w_count_nxt  = r_count + LEN_W'(1);
        end
      end

      S_DONE: begin
        if (i_res_ready) begin
          w_res_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_busy      = r_busy;
  assign o_mac_en    = r_mac_en;
  assign o_mac_clr   = r_mac_clr;
  assign o_mac_a     = r_mac_a;
  assign o_mac_b     = r_mac_b;
  assign o_res_data  = r_res_data;
  assign o_res_valid = r_res_valid;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: FWFT FIFO models, a behavioural pipelined MAC,
// a per-cycle compare process plus directed jobs with literal results.
module tb_mac_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        busy;
  logic        a_empty, b_empty;
  logic [7:0]  a_data, b_data;
  logic        a_rden, b_rden;
  logic        mac_en, mac_clr;
  logic [7:0]  mac_a, mac_b;
  logic [23:0] mac_cout;
  logic [23:0] res_data;
  logic        res_valid;
  logic        res_ready;

  always #5 clk = ~clk;

  mac_seq_ctrl #(.LEN_W(8), .MAC_LAT(3)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_len       (len),
    .o_busy      (busy),
    .i_a_empty   (a_empty),
    .i_a_data    (a_data),
    .o_a_rden    (a_rden),
    .i_b_empty   (b_empty),
    .i_b_data    (b_data),
    .o_b_rden    (b_rden),
    .o_mac_en    (mac_en),
    .o_mac_clr   (mac_clr),
    .o_mac_a     (mac_a),
    .o_mac_b     (mac_b),
    .i_mac_cout  (mac_cout),
    .o_res_data  (res_data),
    .o_res_valid (res_valid),
    .i_res_ready (res_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- FWFT FIFO models ----------------
  logic [7:0] a_mem [0:511];
  logic [7:0] b_mem [0:511];
  int a_wr = 0, a_rd = 0, b_wr = 0, b_rd = 0;
  logic flush = 1'b0;
  int a_pops = 0, b_pops = 0;
  int total_sum = 0;   // sum of products of every popped pair

  assign a_empty = (a_wr == a_rd);
  assign b_empty = (b_wr == b_rd);
  assign a_data  = a_mem[a_rd[8:0]];
  assign b_data  = b_mem[b_rd[8:0]];

  always @(posedge clk) begin
    if (a_rden) a_pops <= a_pops + 1;
    if (b_rden) b_pops <= b_pops + 1;
    if (a_rden && b_rden) total_sum <= total_sum + int'(a_data) * int'(b_data);
    if (flush) begin
      a_rd <= a_wr;
      b_rd <= b_wr;
    end else begin
      if (a_rden) a_rd <= a_rd + 1;
      if (b_rden) b_rd <= b_rd + 1;
    end
  end

  task automatic push_a(input int v);
    a_mem[a_wr[8:0]] = v[7:0];
    a_wr++;
  endtask

  task automatic push_b(input int v);
    b_mem[b_wr[8:0]] = v[7:0];
    b_wr++;
  endtask

  // ---------------- behavioural MAC (3-stage) ----------------
  logic [15:0] p1 = '0, p2 = '0;
  logic [23:0] acc = '0;
  assign mac_cout = acc;

  always @(posedge clk) begin
    if (mac_clr) begin
      p1 <= '0; p2 <= '0; acc <= '0;
    end else if (mac_en) begin
      p1  <= 16'(mac_a) * 16'(mac_b);
      p2  <= p1;
      acc <= acc + 24'(p2);
    end
  end

  // ---------------- strobe counters ----------------
  int clr_total = 0, en_total = 0, en_no_clr = 0;
  int clr_base = 0, en_base = 0, base_sum = 0, a_base = 0, b_base = 0;

  always @(posedge clk) begin
    if (mac_clr) clr_total <= clr_total + 1;
    if (mac_en) en_total <= en_total + 1;
    if (mac_en && clr_total == clr_base) en_no_clr <= en_no_clr + 1;
  end

  // ---------------- per-cycle compare process ----------------
  logic mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("rden_pair", int'(a_rden), int'(b_rden));
      if (a_rden) chk("pop_needs_both", int'(a_empty | b_empty), 0);
      chk("clr_en_excl", int'(mac_clr & mac_en), 0);
      if (res_valid) chk("res_model", int'(res_data), total_sum - base_sum);
      if (!busy) chk("idle_quiet", int'(mac_en | a_rden | res_valid), 0);
    end
  end

  // ---------------- job helpers ----------------
  task automatic start_job(input int n);
    base_sum = total_sum;
    clr_base = clr_total;
    en_base  = en_total;
    a_base   = a_pops;
    b_base   = b_pops;
    len      = n[7:0];
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // cyc counts clock edges after the edge that accepted start
  task automatic wait_result(output int cyc);
    cyc = 0;
    while (!res_valid && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    if (!res_valid) chk("result_timeout", 0, 1);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  int cyc;
  int n_wait;

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    len       = '0;
    res_ready = 1'b1;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_busy",      int'(busy),      0);
    chk("rst_mac_en",    int'(mac_en),    0);
    chk("rst_mac_clr",   int'(mac_clr),   0);
    chk("rst_mac_a",     int'(mac_a),     0);
    chk("rst_mac_b",     int'(mac_b),     0);
    chk("rst_res_data",  int'(res_data),  0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_rden",      int'(a_rden | b_rden), 0);
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // basic: 1*5+2*6+3*7+4*8 = 70, valid at cycle 2+4+3
    for (int i = 0; i < 4; i++) begin
      push_a(i + 1);
      push_b(i + 5);
    end
    start_job(4);
    wait_result(cyc);
    chk("basic_latency", cyc, 9);
    chk("basic_res", int'(res_data), 70);
    @(negedge clk);
    chk("basic_valid_1cyc", int'(res_valid), 0);
    chk("basic_busy_after", int'(busy), 0);
    chk("basic_a_pops", a_pops - a_base, 4);
    chk("basic_b_pops", b_pops - b_base, 4);
    chk("basic_en_cnt", en_total - en_base, 7);
    chk("basic_clr_cnt", clr_total - clr_base, 1);

    // stall: B's second word arrives late; 10*3+20*2+30*1 = 100
    push_a(10); push_a(20); push_a(30);
    push_b(3);
    start_job(3);
    repeat (5) @(negedge clk);
    chk("stall_a_pops_gap", a_pops - a_base, 1);
    chk("stall_b_pops_gap", b_pops - b_base, 1);
    chk("stall_busy", int'(busy), 1);
    push_b(2); push_b(1);
    wait_result(cyc);
    chk("stall_res", int'(res_data), 100);
    chk("stall_a_pops", a_pops - a_base, 3);
    @(negedge clk);

    // max: 255 pairs of 255*255 -> 0xFD02FF
    for (int i = 0; i < 255; i++) begin
      push_a(255);
      push_b(255);
    end
    start_job(255);
    wait_result(cyc);
    chk("max_res", int'(res_data), 16581375);
    chk("max_latency", cyc, 260);
    chk("max_clr_once", clr_total - clr_base, 1);
    chk("max_en_before_clr", en_no_clr, 0);
    chk("max_en_cnt", en_total - en_base, 258);
    @(negedge clk);

    // backpressure: 7*6 = 42 held while ready low; starts in DONE ignored
    res_ready = 1'b0;
    push_a(7); push_b(6);
    start_job(1);
    wait_result(cyc);
    chk("bp_res", int'(res_data), 42);
    for (int i = 0; i < 10; i++) begin
      start = (i % 3 == 0);
      len   = 8'd5;
      @(negedge clk);
      chk("bp_hold_valid", int'(res_valid), 1);
      chk("bp_hold_data",  int'(res_data),  42);
      chk("bp_hold_busy",  int'(busy),      1);
    end
    res_ready = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("bp_release_valid", int'(res_valid), 0);
    chk("bp_release_busy",  int'(busy),      0);
    @(negedge clk);
    chk("bp_start_ignored", int'(busy), 0);
    chk("bp_no_pops", a_pops - a_base, 1);

    // back-to-back job: 2*3+2*3 = 12, not accumulated onto 42
    push_a(2); push_a(2);
    push_b(3); push_b(3);
    start_job(2);
    wait_result(cyc);
    chk("b2b_res", int'(res_data), 12);
    chk("b2b_latency", cyc, 7);
    @(negedge clk);

    // len=0 with a pair waiting: no pops, result 0 at cycle 2+3
    push_a(5); push_b(5);
    start_job(0);
    wait_result(cyc);
    chk("len0_latency", cyc, 5);
    chk("len0_res", int'(res_data), 0);
    chk("len0_a_pops", a_pops - a_base, 0);
    chk("len0_b_pops", b_pops - b_base, 0);
    @(negedge clk);

    // reset mid-FEED after two pairs (B starved so the job parks there)
    do_flush();
    for (int i = 1; i <= 4; i++) push_a(i);
    push_b(1); push_b(2);
    start_job(4);
    n_wait = 0;
    while (a_pops - a_base < 2 && n_wait < 50) begin
      @(negedge clk);
      n_wait++;
    end
    chk("rstjob_two_pops", a_pops - a_base, 2);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstjob_busy",   int'(busy),      0);
    chk("rstjob_mac_en", int'(mac_en),    0);
    chk("rstjob_valid",  int'(res_valid), 0);
    rst = 1'b0;
    push_b(3); push_b(4);
    repeat (5) @(negedge clk);
    chk("rstjob_no_more_a", a_pops - a_base, 2);
    chk("rstjob_no_more_b", b_pops - b_base, 2);
    do_flush();
    push_a(9); push_b(9);
    start_job(1);
    wait_result(cyc);
    chk("rstjob_new_res", int'(res_data), 81);
    chk("rstjob_new_latency", cyc, 6);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
